// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, constants and helpers for the stopwatch display
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam int DIGITS   = 4;
    localparam int BIN_W    = 7;
    localparam int BCD_MAX  = 99;
    localparam int DP_DIGIT = 2;

    localparam logic [BIN_W-1:0] BCD_MAX_B = BIN_W'(BCD_MAX);

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // One double-dabble iteration on a two-digit accumulator: add-3 correction, then shift in msb.
    function automatic logic [7:0] dabble_step(input logic [7:0] bcd, input logic msb);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        return {adj[6:0], msb};
    endfunction

    function automatic logic [BIN_W-1:0] clamp_field(input logic [BIN_W-1:0] v);
        return (v > BCD_MAX_B) ? BCD_MAX_B : v;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to active-high {g,f,e,d,c,b,a} segment pattern
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - MM.SS 7-segment driver with clamping, sequential BCD conversion and scan
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*BIN_W-1:0]    time_in,
    input  logic                  hold,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  busy,
    output logic [1:0]            ovf
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    state_t           state;
    logic [2:0]       cnt;
    logic [BIN_W-1:0] bin_min, bin_sec;
    logic [7:0]       acc_min, acc_sec;
    logic [1:0]       clamp;
    logic [7:0]       disp_min, disp_sec;

    logic [PW-1:0]    presc;
    logic [IW-1:0]    idx;
    logic [3:0]       digit;
    logic [6:0]       seg_dec;

    // Conversion FSM: sample/clamp, seven shift-add-3 steps, then an atomic commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            bin_min  <= '0;
            bin_sec  <= '0;
            acc_min  <= 8'd0;
            acc_sec  <= 8'd0;
            clamp    <= 2'b00;
            disp_min <= 8'd0;
            disp_sec <= 8'd0;
            ovf      <= 2'b00;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hold) begin
                        bin_min <= clamp_field(time_in[2*BIN_W-1:BIN_W]);
                        bin_sec <= clamp_field(time_in[BIN_W-1:0]);
                        clamp   <= {time_in[2*BIN_W-1:BIN_W] > BCD_MAX_B,
                                    time_in[BIN_W-1:0] > BCD_MAX_B};
                        acc_min <= 8'd0;
                        acc_sec <= 8'd0;
                        cnt     <= 3'd0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_min <= dabble_step(acc_min, bin_min[BIN_W-1]);
                    acc_sec <= dabble_step(acc_sec, bin_sec[BIN_W-1]);
                    bin_min <= {bin_min[BIN_W-2:0], 1'b0};
                    bin_sec <= {bin_sec[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'(BIN_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp_min <= acc_min;
                    disp_sec <= acc_sec;
                    ovf      <= clamp;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx)
            2'd0:    digit = disp_sec[3:0];
            2'd1:    digit = disp_sec[7:4];
            2'd2:    digit = disp_min[3:0];
            default: digit = disp_min[7:4];
        endcase
    end

    seg7_decode u_decode (
        .bcd (digit),
        .seg (seg_dec)
    );

    // Scan never stalls; blanking only masks the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            seg   <= 7'd0;
            an    <= '0;
            dp    <= 1'b0;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            if (blank) begin
                seg <= 7'd0;
                an  <= '0;
                dp  <= 1'b0;
            end else begin
                an  <= DIGITS'(1) << idx;
                seg <= (LZ_SUPPRESS && idx == IW'(DIGITS - 1) && disp_min[7:4] == 4'd0)
                       ? SEG_BLANK : seg_dec;
                dp  <= (idx == IW'(DP_DIGIT));
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - scoreboard bench for stopwatch_display
module tb_stopwatch_display;

    localparam int SD = 4;

    typedef struct packed {
        logic [27:0] segs;
        logic [1:0]  ovf;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] time_in;
    logic        hold;
    logic        blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;
    logic [1:0]  ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int scan_edges = 0;

    frame_t sb[$];

    always #5 clk = ~clk;

    stopwatch_display #(.SCAN_DIV(SD), .LZ_SUPPRESS(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .time_in (time_in),
        .hold    (hold),
        .blank   (blank),
        .seg     (seg),
        .an      (an),
        .dp      (dp),
        .busy    (busy),
        .ovf     (ovf)
    );

    always @(posedge clk) begin
        if (rst) scan_edges <= 0;
        else     scan_edges <= scan_edges + 1;
    end

    // Monitor: collects one full scan (0001..1000) and checks it against the oldest expectation.
    logic [3:0]  prev_an = 4'd0;
    logic [27:0] got;
    frame_t      exp_f;
    int          run = 0;
    int          dig = 0;
    bit          collecting = 0;
    bit          frame_ok;

    always @(negedge clk) begin
        if (an != prev_an) begin
            if (collecting) begin
                if (run != SD) frame_ok = 0;
                dig = dig + 1;
                if (an != (4'b0001 << dig)) frame_ok = 0;
                got[dig*7 +: 7] = seg;
                if (dp != (dig == 2)) frame_ok = 0;
                if (dig == 3) begin
                    exp_f = sb.pop_front();
                    n_checks++;
                    if (!frame_ok || got != exp_f.segs || ovf != exp_f.ovf) begin
                        n_fail++;
                        $display("FAIL frame: seg=%h ovf=%b scan_ok=%0d, required seg=%h ovf=%b scan_ok=1",
                                 got, ovf, frame_ok, exp_f.segs, exp_f.ovf);
                    end
                    collecting = 0;
                end
            end else if (sb.size() > 0 && an == 4'b0001) begin
                collecting = 1;
                dig        = 0;
                frame_ok   = 1;
                got        = '0;
                got[6:0]   = seg;
                if (dp) frame_ok = 0;
            end
            run = 1;
        end else begin
            run = run + 1;
        end
        prev_an = an;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [6:0] d3, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0,
                                input logic [1:0] o);
        frame_t f;
        f.segs = {d3, d2, d1, d0};
        f.ovf  = o;
        sb.push_back(f);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("scoreboard_drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_busy(input logic level, input string name);
        int n = 0;
        while (busy !== level && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== level) check(name, 32'(busy), 32'(level));
    endtask

    task automatic measure_busy(input string name);
        int n = 0;
        wait_busy(1'b0, "busy_fall_timeout");
        wait_busy(1'b1, "busy_rise_timeout");
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'd8);
    endtask

    task automatic wait_commit();
        wait_busy(1'b1, "busy_rise_timeout");
        wait_busy(1'b0, "busy_fall_timeout");
    endtask

    initial begin
        rst     = 1'b1;
        time_in = 14'd0;
        hold    = 1'b0;
        blank   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_seg",  32'(seg),  32'h00);
        check("reset_an",   32'(an),   32'h0);
        check("reset_dp",   32'(dp),   32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_ovf",  32'(ovf),  32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_an",  32'(an),  32'h1);
        check("first_seg", 32'(seg), 32'h3F);

        // 00:00 with leading-zero suppression on the minutes tens
        expect_frame(7'h00, 7'h3F, 7'h3F, 7'h3F, 2'b00);
        wait_empty();

        time_in = {7'd12, 7'd34};
        measure_busy("busy_len_1234");
        repeat (18) @(negedge clk);
        expect_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 2'b00);
        wait_empty();
        measure_busy("busy_len_repeat");

        time_in = {7'd127, 7'd59};
        repeat (18) @(negedge clk);
        expect_frame(7'h6F, 7'h6F, 7'h6D, 7'h6F, 2'b10);
        wait_empty();

        time_in = {7'd5, 7'd100};
        repeat (18) @(negedge clk);
        expect_frame(7'h00, 7'h6D, 7'h6F, 7'h6F, 2'b01);
        wait_empty();

        // Reset on the 4th cycle of a 45.45 conversion; hold keeps the FSM idle afterwards.
        time_in = {7'd45, 7'd45};
        wait_commit();
        wait_busy(1'b1, "busy_rise_timeout");
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        hold = 1'b1;
        @(negedge clk);
        check("midrst_seg",  32'(seg),  32'h00);
        check("midrst_an",   32'(an),   32'h0);
        check("midrst_ovf",  32'(ovf),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        expect_frame(7'h00, 7'h3F, 7'h3F, 7'h3F, 2'b00);
        wait_empty();
        hold = 1'b0;

        time_in = {7'd1, 7'd5};
        repeat (18) @(negedge clk);
        expect_frame(7'h00, 7'h06, 7'h3F, 7'h6D, 2'b00);
        wait_empty();

        hold = 1'b1;
        wait_busy(1'b0, "busy_fall_timeout");
        time_in = {7'd1, 7'd6};
        repeat (40) @(negedge clk);
        expect_frame(7'h00, 7'h06, 7'h3F, 7'h6D, 2'b00);
        wait_empty();

        begin
            int n = 0;
            bit seen = 0;
            hold = 1'b0;
            while (n < 30 && !(seen && busy === 1'b0)) begin
                @(negedge clk);
                n++;
                if (busy === 1'b1) seen = 1;
            end
            check("unhold_commit_cycles", 32'(n), 32'd9);
        end
        expect_frame(7'h00, 7'h06, 7'h3F, 7'h7D, 2'b00);
        wait_empty();

        // hold raised mid-SHIFT still commits 02.07
        time_in = {7'd2, 7'd7};
        wait_commit();
        wait_busy(1'b1, "busy_rise_timeout");
        repeat (2) @(negedge clk);
        hold    = 1'b1;
        time_in = {7'd3, 7'd0};
        repeat (30) @(negedge clk);
        expect_frame(7'h00, 7'h5B, 7'h3F, 7'h07, 2'b00);
        wait_empty();
        hold = 1'b0;

        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("blank_outputs", {23'd0, an, seg, dp}, 32'd0);
        end
        blank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_blank_an", 32'(an), 32'(4'b0001 << (((scan_edges - 1) / SD) % 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream consumer of the stopwatch counter's packed minutes/seconds time value.
- Clamps each field to 0-99 and converts it to BCD with a sequential shift-add-3 (double-dabble) FSM.
- Drives a 4-digit multiplexed 7-segment display (MM.SS) with a registered scan.
- Supports lap freeze (hold) and display blanking.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays lit; minimum 2.
- LZ_SUPPRESS, 1: when 1, the minutes-tens digit is blanked if it is 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- time_in  in  14  {minutes[13:7], seconds[6:0]}, unsigned binary
- hold  in  1  freeze displayed value (lap)
- blank  in  1  force all anodes off
- seg  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}
- an  out  4  digit anode, one-hot, active-high; an[0] = seconds ones … an[3] = minutes tens
- dp  out  1  decimal point, lit only on digit 2 (MM.SS separator)
- busy  out  1  high while a conversion is in progress
- ovf  out  2  {min_clamped, sec_clamped}, updated at commit

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - Reset is synchronous, active-high, on rst.
  - All state updates on the posedge of clk.
- Reset values:
  - seg=0, an=0, dp=0, busy=0, ovf=0.
  - BCD display registers = 00:00.
  - FSM in IDLE, shift count 0, prescaler 0, digit index 0.
- rst has priority over every other input.
- Reset asserted mid-conversion aborts it: display registers keep their reset value (00:00) and no partial commit occurs.
- FSM states:
  - IDLE:
    - If hold=0: sample time_in and clamp each field (value >99 → 99, corresponding clamp flag set).
    - Load two 7-bit binary shift registers, clear the BCD accumulators, set shift count=0, go to SHIFT.
    - If hold=1: stay in IDLE; display registers unchanged.
  - SHIFT:
    - Per cycle, per field: add 3 to any BCD nibble ≥5, then shift left one bit, taking the binary MSB in.
    - After the 7th shift (count=6), go to COMMIT.
  - COMMIT: write both BCD accumulators and the clamp flags to the display registers and ovf atomically; go to IDLE.
- Latency and throughput:
  - time_in sampled at edge T is visible in the display registers after edge T+8.
  - Next sample at edge T+9; free-running refresh period is 9 cycles.
  - busy=1 in SHIFT and COMMIT, 0 in IDLE.
- hold:
  - Checked only in IDLE.
  - Asserting hold mid-conversion does not abort; the in-flight value commits, then the display freezes.
  - Deasserting hold resumes sampling on the next IDLE cycle.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→3→0.
  - The scan runs continuously, independent of FSM state, hold and blank.
- Output register (seg/an/dp registered; one cycle after the index changes):
  - an = 1<<index.
  - seg = decode(digit[index]).
  - dp = (index==2).
- Blanking:
  - blank=1 forces an=0, seg=0, dp=0 on the next cycle.
  - LZ_SUPPRESS=1 with minutes-tens digit 0 forces seg=0 while index=3; an still asserts.
- Decoder (active-high): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Codes 10-15 → 0x00; unreachable given clamping.
- After reset, the first cycle gives an=0001, seg=0x3F.

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state enum (IDLE, SHIFT, COMMIT).
  - DIGITS=4, BIN_W=7, BCD_MAX=99.
  - SEG_* digit code constants.
  - DP_DIGIT=2.
- One natural sub-module: seg7_decode (4-bit BCD in, 7-bit active-high segments out, combinational), instantiated once on the muxed digit.

Test Plan:
- Reset, time_in=0, SCAN_DIV=4:
  - Display 00:00 after 9 cycles.
  - an sequences 0001,0010,0100,1000, each held 4 cycles.
  - seg=0x3F on digits 0-2; seg=0 on digit 3 (LZ_SUPPRESS).
- time_in={7'd12,7'd34}:
  - After ≤18 cycles the scan shows seg 0x66, 0x4F, 0x5B, 0x06 for an 0001..1000.
  - dp=1 only with an=0100; busy high for exactly 8 cycles per conversion.
- time_in={7'd127,7'd59}: display 99.59 and ovf=2'b10; then time_in={7'd5,7'd100} → 05.99, ovf=2'b01.
- Display showing 01.05, hold=1, time_in→01.06:
  - Display stays 01.05 indefinitely.
  - Deassert hold → 01.06 committed within 9 cycles.
  - hold raised during SHIFT still commits the in-flight value.
- rst pulsed at cycle 4 of a conversion of 45.45: next cycle seg=0, an=0, ovf=0, busy=0, and a later scan shows 00.00.
- blank=1 for 10 cycles: an=0, seg=0, dp=0 from the following cycle; the scan index keeps advancing, so on release the digit shown matches the free-running index.
